// File: rtl/imm_gen_pipe.sv
// Immediate generator with a 2-entry in-order output buffer.
// Decodes RISC-V immediates at accept time and holds {imm, illegal, tag}
// until the consumer takes them.

package imm_gen_pkg;
    typedef enum logic [2:0] {
        IMM_I_TYPE  = 3'd0,
        IMM_S_TYPE  = 3'd1,
        IMM_B_TYPE  = 3'd2,
        IMM_U_TYPE  = 3'd3,
        IMM_J_TYPE  = 3'd4,
        IMM_Z_TYPE  = 3'd5,
        IMM_SH_TYPE = 3'd6
    } imm_sel_e;
endpackage

module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  imm_sel_e         imm_sel,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_o,
    output logic             illegal_o,
    output logic [TAG_W-1:0] tag_o
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_gen_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    // Opcode field is not part of any immediate.
    logic unused_opcode;
    assign unused_opcode = ^instr[6:0];

    logic [XLEN-1:0]  dec_imm;
    logic             dec_illegal;

    logic [XLEN-1:0]  imm_mem [2];
    logic             ill_mem [2];
    logic [TAG_W-1:0] tag_mem [2];

    logic [1:0] count;
    logic       wr_ptr;
    logic       rd_ptr;
    logic       accept;
    logic       pop;

    // Handshake depends only on the registered occupancy.
    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Immediate decode; signed casts sign-extend from instr[31] to XLEN.
    always_comb begin
        dec_imm     = '0;
        dec_illegal = 1'b0;
        case (imm_sel)
            IMM_I_TYPE: dec_imm = XLEN'($signed(instr[31:20]));
            IMM_S_TYPE: dec_imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            IMM_B_TYPE: dec_imm = XLEN'($signed({instr[31], instr[7], instr[30:25],
                                                  instr[11:8], 1'b0}));
            IMM_U_TYPE: dec_imm = XLEN'($signed({instr[31:12], 12'b0}));
            IMM_J_TYPE: dec_imm = XLEN'($signed({instr[31], instr[19:12], instr[20],
                                                  instr[30:21], 1'b0}));
            IMM_Z_TYPE: dec_imm = XLEN'(instr[19:15]);
            IMM_SH_TYPE: begin
                if (XLEN == 64) dec_imm = XLEN'(instr[25:20]);
                else            dec_imm = XLEN'(instr[24:20]);
            end
            default: begin
                dec_imm     = '0;
                dec_illegal = 1'b1;
            end
        endcase
    end

    // Buffer storage; contents are only observable while counted as valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            imm_mem[wr_ptr] <= dec_imm;
            ill_mem[wr_ptr] <= dec_illegal;
            tag_mem[wr_ptr] <= tag_i;
        end
    end

    // Occupancy and pointers; reset beats flush, flush drops any handshake.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (accept) wr_ptr <= ~wr_ptr;
            if (pop)    rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, accept} - {1'b0, pop};
        end
    end

    assign imm_o     = out_valid ? imm_mem[rd_ptr] : '0;
    assign illegal_o = out_valid ? ill_mem[rd_ptr] : 1'b0;
    assign tag_o     = out_valid ? tag_mem[rd_ptr] : '0;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus.

module tb_imm_gen_pipe;
    import imm_gen_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] instr;
    imm_sel_e    imm_sel;
    logic [4:0]  tag_i;
    logic        out_ready;

    logic        in_ready32, out_valid32, illegal32;
    logic [31:0] imm32;
    logic [4:0]  tag32;
    logic        in_ready64, out_valid64, illegal64;
    logic [63:0] imm64;
    logic [4:0]  tag64;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(5)) u_dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
        .instr(instr), .imm_sel(imm_sel), .tag_i(tag_i), .out_valid(out_valid32),
        .out_ready(out_ready), .imm_o(imm32), .illegal_o(illegal32), .tag_o(tag32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(5)) u_dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .instr(instr), .imm_sel(imm_sel), .tag_i(tag_i), .out_valid(out_valid64),
        .out_ready(out_ready), .imm_o(imm64), .illegal_o(illegal64), .tag_o(tag64)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] ins, input imm_sel_e sel, input logic [4:0] tg);
        in_valid = 1'b1;
        instr    = ins;
        imm_sel  = sel;
        tag_i    = tg;
    endtask

    task automatic head32(input string nm, input logic [31:0] imm, input logic ill,
                          input logic [4:0] tg);
        check({nm, ".valid"}, out_valid32, 1'b1);
        check({nm, ".imm"}, imm32, imm);
        check({nm, ".ill"}, illegal32, ill);
        check({nm, ".tag"}, tag32, tg);
    endtask

    task automatic empty32(input string nm);
        check({nm, ".valid"}, out_valid32, 1'b0);
        check({nm, ".imm"}, imm32, 32'h0);
        check({nm, ".ill"}, illegal32, 1'b0);
        check({nm, ".tag"}, tag32, 5'd0);
        check({nm, ".rdy"}, in_ready32, 1'b1);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; instr = '0;
        imm_sel = IMM_I_TYPE; tag_i = '0; out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        empty32("reset");
        check("reset.imm64", imm64, 64'h0);
        check("reset.valid64", out_valid64, 1'b0);

        // Single I-type, then back-to-back S/U/J with continuous draining
        offer(32'hFFF00093, IMM_I_TYPE, 5'd3);
        tick();
        head32("i", 32'hFFFFFFFF, 1'b0, 5'd3);
        check("i.imm64", imm64, 64'hFFFFFFFFFFFFFFFF);
        offer(32'hFE112E23, IMM_S_TYPE, 5'd4);
        tick();
        head32("s", 32'hFFFFFFFC, 1'b0, 5'd4);
        check("s.imm64", imm64, 64'hFFFFFFFFFFFFFFFC);
        offer(32'h123450B7, IMM_U_TYPE, 5'd5);
        tick();
        head32("u", 32'h12345000, 1'b0, 5'd5);
        check("u.imm64", imm64, 64'h0000000012345000);
        offer(32'h0010006F, IMM_J_TYPE, 5'd6);
        tick();
        head32("j", 32'h00000800, 1'b0, 5'd6);
        offer(32'h03F0D093, IMM_SH_TYPE, 5'd7);
        tick();
        head32("sh", 32'h0000001F, 1'b0, 5'd7);
        check("sh.imm64", imm64, 64'h3F);
        offer(32'h03F0D093, IMM_Z_TYPE, 5'd8);
        tick();
        head32("z", 32'h00000001, 1'b0, 5'd8);
        offer(32'h80000463, IMM_B_TYPE, 5'd10);
        tick();
        head32("b", 32'hFFFFF008, 1'b0, 5'd10);
        check("b.imm64", imm64, 64'hFFFFFFFFFFFFF008);
        offer(32'hFFFFFFFF, imm_sel_e'(3'd7), 5'd9);
        tick();
        head32("bad", 32'h0, 1'b1, 5'd9);
        check("bad.ill64", illegal64, 1'b1);
        in_valid = 1'b0;
        tick();
        empty32("drained");

        // Backpressure: two accepted, third held off until draining
        out_ready = 1'b0;
        offer(32'h00500093, IMM_I_TYPE, 5'd1);
        tick();
        head32("bp_a", 32'd5, 1'b0, 5'd1);
        check("bp_a.rdy", in_ready32, 1'b1);
        offer(32'h00600093, IMM_I_TYPE, 5'd2);
        tick();
        head32("bp_b", 32'd5, 1'b0, 5'd1);
        check("bp_b.rdy", in_ready32, 1'b0);
        offer(32'h00700093, IMM_I_TYPE, 5'd3);
        for (int i = 0; i < 2; i++) begin
            tick();
            head32("bp_hold", 32'd5, 1'b0, 5'd1);
            check("bp_hold.rdy", in_ready32, 1'b0);
        end
        out_ready = 1'b1;
        tick();
        head32("bp_pop1", 32'd6, 1'b0, 5'd2);
        check("bp_pop1.rdy", in_ready32, 1'b1);
        tick();
        head32("bp_pop2", 32'd7, 1'b0, 5'd3);
        in_valid = 1'b0;
        tick();
        empty32("bp_done");

        // Flush while full discards stored and offered entries
        out_ready = 1'b0;
        offer(32'h00100093, IMM_I_TYPE, 5'd11);
        tick();
        offer(32'h00200093, IMM_I_TYPE, 5'd12);
        tick();
        offer(32'h00300093, IMM_I_TYPE, 5'd13);
        flush = 1'b1;
        #1;
        check("flush.rdy_during", in_ready32, 1'b0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        empty32("flush");
        tick();
        empty32("flush_after");

        // Reset mid-stream overrides flush and the pending handshake
        out_ready = 1'b1;
        offer(32'h00400093, IMM_I_TYPE, 5'd14);
        tick();
        head32("pre_rst", 32'd4, 1'b0, 5'd14);
        out_ready = 1'b0;
        rst = 1'b1;
        flush = 1'b1;
        tick();
        rst = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        empty32("mid_rst");
        check("mid_rst.imm64", imm64, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
